anillo_captura: RTL and testbench
=================================

Name: anillo_captura

Overview:
Receive-side counterpart of the anode ring decoder. It samples a multiplexed 7-segment bus (ring-scanned anodes plus shared segment lines) and rebuilds the four digit patterns into static registers. It checks the scan for one-hot violations and out-of-order digits, and reports frame completion. It sits in the display-loopback and self-test path, fed by the board's anode and segment nets.

Parameters:
SEG_W, 8, segment bus width (7 segments + decimal point)
MIN_DWELL, 4, consecutive stable registered cycles required before a digit is captured (legal range 2..255)
ANODE_ACTIVE_LOW, 1, 1 = anode asserted when its bit is 0; 0 = asserted when 1

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Reset  input  1  synchronous reset, active-low
i_Anodos  input  4  anode lines from the display driver, ring order bit0->bit3
i_Segmentos  input  SEG_W  shared segment lines
o_Digitos  output  4*SEG_W  captured patterns; digit n at bits [n*SEG_W +: SEG_W]
o_Valid  output  4  bit n set once digit n has been captured since reset
o_Sel  output  2  index of the most recently captured digit
o_Wr  output  1  one-cycle pulse on every digit capture
o_Frame  output  1  one-cycle pulse when digit 3 is captured while o_Valid is 4'b1111 after that capture
o_SeqErr  output  1  one-cycle pulse when a captured index is not (previous captured index + 1) mod 4
o_OneHotErr  output  1  one-cycle pulse on the first registered cycle with more than one anode asserted

Behaviour:
- Reset: i_Reset==0 sampled on an edge clears every output, o_Digitos, the counter, the input registers and the "have previous" flag. State goes to IDLE. Reset mid-dwell discards the partial capture.
- Input stage: i_Anodos and i_Segmentos are registered once. Anodes are normalised to active-high (a = ~in when ANODE_ACTIVE_LOW=1). All checks use the registered values.
- One-hot classes: a has exactly one bit set = legal; a == 0 = blanking, legal and no error; two or more bits set = illegal.
- Dwell counter is 8 bits wide. It saturates at MIN_DWELL. It clears whenever a or the segment value differs from the previous registered cycle, or a is not one-hot. Otherwise it increments.
- FSM:
  - IDLE: a not one-hot.
  - DWELL: a one-hot, counter below MIN_DWELL.
  - CAPTURED: digit already taken for this anode slot.
  - IDLE -> DWELL on a legal one-hot a.
  - DWELL -> CAPTURED when the counter reaches MIN_DWELL.
  - CAPTURED -> DWELL on a change to a different one-hot a, or on a segment change under the same anode. A segment change re-captures the same slot.
  - Any state -> IDLE when a is not one-hot.
- Capture (DWELL->CAPTURED edge), all on the same edge:
  - write the registered segments into digit idx, where idx = position of the set bit;
  - set o_Valid[idx];
  - set o_Sel = idx;
  - pulse o_Wr.
- Latency: segments and anode first presented before edge k become registered at k. The capture is visible after edge k+MIN_DWELL, provided the inputs hold stable through edge k+MIN_DWELL-1.
- Sequence check: o_SeqErr pulses with o_Wr when "have previous" is set and idx != (o_Sel_old+1) mod 4. Index 3 -> 0 wrap is legal. A re-capture of the same idx counts as a sequence error. The first capture after reset never flags. The checker resynchronises to the new idx.
- Frame: o_Frame pulses with o_Wr when idx==3 and all four o_Valid bits are set after the capture. It fires on every subsequent pass through digit 3.
- o_OneHotErr: pulses once per entry into an illegal pattern. It does not repeat while the same illegal pattern persists.
- Pulses are registered outputs and are never asserted during or on the edge of reset.

Test Plan:
- Reset hold: i_Reset=0 for 3 edges with arbitrary inputs -> o_Digitos=0, o_Valid=0, o_Sel=0, no pulses.
- Clean ring, MIN_DWELL=4, ANODE_ACTIVE_LOW=1: anodes 1110,1101,1011,0111, 6 cycles each, segments 8'hC0,8'hF9,8'hA4,8'hB0.
  - Expected: o_Digitos = {B0,A4,F9,C0}.
  - Expected: four o_Wr pulses, the first at the 4th edge after the first input is registered.
  - Expected: o_Valid=1111, one o_Frame with the 4th o_Wr, no o_SeqErr.
- Short dwell: anode 1110 held 3 registered cycles, then 1101 held 6 -> digit0 not written, o_Valid=0010, no o_SeqErr (first capture).
- Out of order: after a clean pass, present 1011 directly after digit 0 -> o_SeqErr pulses with the digit-2 o_Wr, o_Sel=2.
- Illegal anodes: 1100 held 5 cycles -> exactly one o_OneHotErr, no capture, state IDLE. Blank 1111 -> no error.
- Reset mid-dwell: drop i_Reset at the 2nd stable cycle, release, keep inputs -> capture occurs MIN_DWELL stable cycles after release, no pulses during reset.

Source files
------------

// File: rtl/anillo_captura.sv
// anillo_captura: rebuilds four digit patterns from a ring-scanned 7-segment bus and flags scan errors
module anillo_captura #(
  parameter int SEG_W            = 8,
  parameter int MIN_DWELL        = 4,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic [3:0]         i_Anodos,
  input  logic [SEG_W-1:0]   i_Segmentos,
  output logic [4*SEG_W-1:0] o_Digitos,
  output logic [3:0]         o_Valid,
  output logic [1:0]         o_Sel,
  output logic               o_Wr,
  output logic               o_Frame,
  output logic               o_SeqErr,
  output logic               o_OneHotErr
);
  typedef enum logic [1:0] {IDLE, DWELL, CAPTURED} st_t;
  localparam logic [7:0] MD  = 8'(MIN_DWELL);
  localparam logic [7:0] MD1 = 8'(MIN_DWELL - 1);
  function automatic logic oh(input logic [3:0] a);
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction
  st_t                st_q, st_d;
  logic [3:0]         an_q, an_d;
  logic [SEG_W-1:0]   seg_q;
  logic [7:0]         cnt_q, cnt_d;
  logic               hp_q, hp_d;
  logic [4*SEG_W-1:0] dig_q, dig_d;
  logic [3:0]         val_q, val_d, val_n;
  logic [1:0]         sel_q, sel_d, idx;
  logic               wr_d, frm_d, seq_d, ohe_d, cap;
  always_comb begin
    an_d  = (ANODE_ACTIVE_LOW != 0) ? ~i_Anodos : i_Anodos;
    // counter tracks how long the value now being registered has been stable
    cnt_d = (!oh(an_d) || an_d != an_q || i_Segmentos != seg_q) ? 8'd0 :
            (cnt_q >= MD) ? cnt_q : cnt_q + 8'd1;
    idx   = {an_q[3] | an_q[2], an_q[3] | an_q[1]};
    cap   = st_q == DWELL && oh(an_q) && cnt_q >= MD1;
    st_d  = !oh(an_q) ? IDLE :
            cap ? CAPTURED :
            (st_q == IDLE || (st_q == CAPTURED && cnt_q == 8'd0)) ? DWELL : st_q;
    val_n = val_q | (4'b1 << idx);
    dig_d = dig_q;
    if (cap) dig_d[idx*SEG_W +: SEG_W] = seg_q;
    val_d = cap ? val_n : val_q;
    sel_d = cap ? idx : sel_q;
    hp_d  = hp_q | cap;
    wr_d  = cap;
    frm_d = cap && idx == 2'd3 && val_n == 4'hF;
    seq_d = cap && hp_q && idx != sel_q + 2'd1;
    ohe_d = an_d != 4'd0 && !oh(an_d) && an_d != an_q;
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      st_q        <= IDLE;
      an_q        <= '0;
      seg_q       <= '0;
      cnt_q       <= '0;
      hp_q        <= 1'b0;
      dig_q       <= '0;
      val_q       <= '0;
      sel_q       <= '0;
      o_Wr        <= 1'b0;
      o_Frame     <= 1'b0;
      o_SeqErr    <= 1'b0;
      o_OneHotErr <= 1'b0;
    end else begin
      st_q        <= st_d;
      an_q        <= an_d;
      seg_q       <= i_Segmentos;
      cnt_q       <= cnt_d;
      hp_q        <= hp_d;
      dig_q       <= dig_d;
      val_q       <= val_d;
      sel_q       <= sel_d;
      o_Wr        <= wr_d;
      o_Frame     <= frm_d;
      o_SeqErr    <= seq_d;
      o_OneHotErr <= ohe_d;
    end
  end
  assign o_Digitos = dig_q;
  assign o_Valid   = val_q;
  assign o_Sel     = sel_q;
endmodule

// File: tb/tb_anillo_captura.sv
// tb_anillo_captura: randomized and directed scoreboard bench against a run-length reference model
module tb_anillo_captura;
  localparam int SW = 8, MD = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] an = 4'hF;
  logic [SW-1:0] seg = '0;
  logic [4*SW-1:0] dig;
  logic [3:0] val;
  logic [1:0] sel;
  logic wr, frm, seqe, ohe;
  anillo_captura #(.SEG_W(SW), .MIN_DWELL(MD), .ANODE_ACTIVE_LOW(1)) dut (
    .i_Clk(clk), .i_Reset(rst_n), .i_Anodos(an), .i_Segmentos(seg),
    .o_Digitos(dig), .o_Valid(val), .o_Sel(sel), .o_Wr(wr),
    .o_Frame(frm), .o_SeqErr(seqe), .o_OneHotErr(ohe));
  always #5 clk = ~clk;
  typedef struct {int edge_n; int idx; logic [SW-1:0] s; bit sq; bit fr;} cap_t;
  cap_t capq[$];
  int   oheq[$];
  int checks = 0, errors = 0, edge_cnt = 0;
  int wr_cnt = 0, frm_cnt = 0, seq_cnt = 0, ohe_cnt = 0, last_wr_edge = -1;
  logic [SW-1:0] m_dig[4] = '{default: '0};
  logic [3:0] m_val = '0;
  int m_sel = 0;
  bit m_hp = 0;
  logic [3:0] run_a = '0;
  logic [SW-1:0] run_s = '0;
  int run_len = 0;
  logic [SW-1:0] ring_seg[4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
  function automatic bit is_oh(input logic [3:0] a);
    return a != 0 && (a & (a - 4'd1)) == 0;
  endfunction
  function automatic int pos(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return 0;
  endfunction
  function automatic logic [3:0] ring(input int d);
    logic [3:0] t;
    t = 4'b1 << d;
    return ~t;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask
  // reference model: a capture happens on the edge where a one-hot (anode, segment) sample
  // has been registered unchanged for exactly MD consecutive edges
  task automatic step(input logic [3:0] raw, input logic [SW-1:0] s, input logic r);
    logic [3:0] a;
    cap_t c;
    int nx;
    @(negedge clk);
    #1;
    an = raw; seg = s; rst_n = r;
    a = ~raw;
    if (!r) begin
      run_a = '0; run_s = '0; run_len = 0;
      m_dig = '{default: '0}; m_val = '0; m_sel = 0; m_hp = 0;
    end else begin
      if (run_len == MD && is_oh(run_a)) begin
        c.edge_n = edge_cnt + 1;
        c.idx = pos(run_a);
        c.s = run_s;
        nx = (m_sel + 1) % 4;
        c.sq = m_hp && c.idx != nx;
        m_dig[c.idx] = run_s;
        m_val[c.idx] = 1'b1;
        c.fr = c.idx == 3 && m_val == 4'hF;
        m_sel = c.idx;
        m_hp = 1;
        capq.push_back(c);
      end
      if (a != 0 && !is_oh(a) && a != run_a) oheq.push_back(edge_cnt + 1);
      if (a == run_a && s == run_s) run_len++;
      else begin run_a = a; run_s = s; run_len = 1; end
    end
    @(posedge clk);
    edge_cnt++;
  endtask
  task automatic hold(input logic [3:0] raw, input logic [SW-1:0] s, input int n);
    for (int i = 0; i < n; i++) step(raw, s, 1'b1);
  endtask
  always @(negedge clk) begin
    bit ew, eo;
    cap_t c;
    if (wr) begin wr_cnt++; last_wr_edge = edge_cnt; end
    if (frm) frm_cnt++;
    if (seqe) seq_cnt++;
    if (ohe) ohe_cnt++;
    ew = capq.size() > 0 && capq[0].edge_n == edge_cnt;
    chk("wr", 64'(wr), 64'(ew));
    if (ew) begin
      c = capq.pop_front();
      chk("sel_on_wr", 64'(sel), 64'(c.idx));
      chk("digit_on_wr", 64'(dig[c.idx*SW +: SW]), 64'(c.s));
      chk("seqerr_on_wr", 64'(seqe), 64'(c.sq));
      chk("frame_on_wr", 64'(frm), 64'(c.fr));
    end else chk("idle_pulses", 64'({frm, seqe}), 64'd0);
    eo = oheq.size() > 0 && oheq[0] == edge_cnt;
    if (eo) void'(oheq.pop_front());
    chk("onehoterr", 64'(ohe), 64'(eo));
    chk("digits", 64'(dig), 64'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
    chk("valid_sel", 64'({val, sel}), 64'({m_val, 2'(m_sel)}));
  end
  initial begin
    int w0, f0, s0, o0, r_edge, kind, len;
    logic [3:0] raw;
    logic [SW-1:0] sv;
    for (int i = 0; i < 3; i++) step(4'($urandom), 8'($urandom), 1'b0);
    @(negedge clk); #2;
    chk("reset_state", 64'({dig, val, sel, wr, frm, seqe, ohe}), 64'd0);
    w0 = wr_cnt; f0 = frm_cnt; s0 = seq_cnt;
    for (int d = 0; d < 4; d++) hold(ring(d), ring_seg[d], 6);
    @(negedge clk); #2;
    chk("ring_digits", 64'(dig), 64'h00000000_B0A4F9C0);
    chk("ring_valid", 64'(val), 64'hF);
    chk("ring_wr_count", 64'(wr_cnt - w0), 64'd4);
    chk("ring_frame_count", 64'(frm_cnt - f0), 64'd1);
    chk("ring_seq_count", 64'(seq_cnt - s0), 64'd0);
    for (int i = 0; i < 2; i++) step(4'hF, 8'h00, 1'b0);
    s0 = seq_cnt;
    hold(4'b1110, 8'h11, 3);
    hold(4'b1101, 8'h22, 6);
    @(negedge clk); #2;
    chk("short_valid", 64'(val), 64'b0010);
    chk("short_seq_count", 64'(seq_cnt - s0), 64'd0);
    for (int d = 0; d < 4; d++) hold(ring(d), ring_seg[d] ^ 8'h0F, 6);
    hold(ring(0), 8'h55, 6);
    s0 = seq_cnt;
    hold(ring(2), 8'h66, 6);
    @(negedge clk); #2;
    chk("ooo_sel", 64'(sel), 64'd2);
    chk("ooo_seq_count", 64'(seq_cnt - s0), 64'd1);
    w0 = wr_cnt; o0 = ohe_cnt;
    hold(4'b1100, 8'h77, 5);
    @(negedge clk); #2;
    chk("illegal_ohe_count", 64'(ohe_cnt - o0), 64'd1);
    chk("illegal_wr_count", 64'(wr_cnt - w0), 64'd0);
    o0 = ohe_cnt;
    hold(4'b1111, 8'h77, 5);
    @(negedge clk); #2;
    chk("blank_ohe_count", 64'(ohe_cnt - o0), 64'd0);
    hold(4'b0111, 8'h3F, 2);
    step(4'b0111, 8'h3F, 1'b0);
    w0 = wr_cnt;
    r_edge = edge_cnt + 1;
    hold(4'b0111, 8'h3F, 6);
    @(negedge clk); #2;
    chk("midreset_wr_count", 64'(wr_cnt - w0), 64'd1);
    chk("midreset_wr_edge", 64'(last_wr_edge), 64'(r_edge + MD));
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      len = $urandom_range(1, 8);
      sv = 8'($urandom_range(0, 3) * 8'h21);
      raw = kind < 6 ? ring((m_sel + 1) % 4) : kind == 6 ? ring($urandom_range(0, 3)) :
            kind == 7 ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 39) == 0) step(raw, sv, 1'b0);
      else hold(raw, sv, len);
    end
    hold(4'hF, 8'h00, 3);
    @(negedge clk); #2;
    chk("queues_drained", 64'(capq.size() + oheq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
